// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared widths, opcode encoding and command payload for the ALU scheduler
package alu_sched_pkg;
  localparam int N_REQ_DEFAULT = 4;
  localparam int DATA_W = 8;
  localparam int OPC_W = 2;
  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;
  typedef struct packed {
    alu_op_e op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; search starts at ptr, ptr moves past each winner
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         accept
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, win;
  logic found;
  always_comb begin
    found = 1'b0;
    win = ptr;
    for (int k = 0; k < N; k++)
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        win = PW'((int'(ptr) + k) % N);
      end
    accept = found && en && !rst;
    grant = accept ? (N'(1) << win) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (accept) ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one pipelined ALU among N_REQ requesters,
// with a tag pipeline that returns each result to its owner in accept order.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int ALU_LAT = 2,
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OPC_W-1:0]  req_opcode,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [OPC_W-1:0]        alu_opcode,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_result,
  output logic                    rsp_valid,
  output logic [IW-1:0]           rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    idle
);
  logic accept;
  logic [IW-1:0] sel_id;
  alu_cmd_t cmd, alu_cmd;
  // stage 0 holds the op whose operands sit on alu_*; stage ALU_LAT sees its result
  logic [ALU_LAT:0] tv;
  logic [ALU_LAT:0][IW-1:0] tid;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req(req_valid),
    .grant(req_ready),
    .accept(accept)
  );
  always_comb begin
    sel_id = '0;
    cmd = '0;
    for (int i = 0; i < N_REQ; i++)
      if (req_ready[i]) begin
        sel_id = IW'(i);
        cmd = '{op: alu_op_e'(req_opcode[OPC_W*i +: OPC_W]), a: req_a[DATA_W*i +: DATA_W], b: req_b[DATA_W*i +: DATA_W]};
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_cmd <= '0;
      tv <= '0;
      tid <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) alu_cmd <= cmd;
      tv <= {tv[ALU_LAT-1:0], accept};
      tid <= {tid[ALU_LAT-1:0], sel_id};
      rsp_valid <= tv[ALU_LAT];
      if (tv[ALU_LAT]) begin
        rsp_id <= tid[ALU_LAT];
        rsp_data <= alu_result;
      end
    end
  assign alu_opcode = alu_cmd.op;
  assign alu_a = alu_cmd.a;
  assign alu_b = alu_cmd.b;
  assign idle = ~|tv & ~rsp_valid;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: randomized and directed stimulus against a queue-based scoreboard
module tb_alu_rr_scheduler;
  localparam int N = 4;
  localparam int LAT = 2;
  logic clk = 1'b0, rst, en;
  logic [N-1:0] req_valid, req_ready;
  logic [2*N-1:0] req_opcode;
  logic [8*N-1:0] req_a, req_b;
  logic [1:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_result, rsp_data;
  logic rsp_valid, idle;
  logic [1:0] rsp_id;
  alu_rr_scheduler #(.N_REQ(N), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .idle(idle)
  );
  always #5 clk = ~clk;

  function automatic logic [7:0] f(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    return op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? (a & b) : (a | b);
  endfunction

  // external two-stage ALU the scheduler drives
  logic [7:0] p1, p2;
  always @(posedge clk) begin
    p1 <= f(alu_opcode, alu_a, alu_b);
    p2 <= p1;
  end
  assign alu_result = p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {int id; int res; int due;} exp_t;
  typedef struct {int id; int data; int cyc;} ev_t;
  exp_t q[$];
  ev_t glog[$], rlog[$];
  logic idle_h [0:4095];
  logic [N-1:0] acc_mask = '0, hold = '0;
  int p = 0, lid = 0, ldat = 0, ealu = 0;

  function automatic int pick(logic [N-1:0] v, int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // scoreboard: grant choice from a rotating search, results due LAT+2 negedges after the pre-accept one
  always @(negedge clk) begin
    int g;
    bit erv;
    if (rst) begin
      q.delete();
      p = 0; lid = 0; ldat = 0; ealu = 0;
      acc_mask = '0;
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_idle", int'(idle), 1);
      chk("rst_rsp", int'({rsp_id, rsp_data}), 0);
      chk("rst_alu", int'({alu_opcode, alu_a, alu_b}), 0);
    end else begin
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      g = en ? pick(req_valid, p) : -1;
      chk("ready", int'(req_ready), g >= 0 ? (1 << g) : 0);
      erv = q.size() > 0 && q[0].due == cyc;
      if (erv) begin
        lid = q[0].id;
        ldat = q[0].res;
      end
      chk("rsp_valid", int'(rsp_valid), int'(erv));
      chk("idle", int'(idle), int'(q.size() == 0));
      chk("rsp_id", int'(rsp_id), lid);
      chk("rsp_data", int'(rsp_data), ldat);
      chk("alu_cmd", int'({alu_opcode, alu_a, alu_b}), ealu);
      if (erv) void'(q.pop_front());
      acc_mask = g >= 0 ? N'(1 << g) : '0;
      if (g >= 0) begin
        q.push_back('{id: g, res: int'(f(req_opcode[2*g +: 2], req_a[8*g +: 8], req_b[8*g +: 8])), due: cyc + LAT + 2});
        ealu = int'({req_opcode[2*g +: 2], req_a[8*g +: 8], req_b[8*g +: 8]});
        p = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc < 4096) idle_h[cyc] = idle;
    if (!rst) begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) glog.push_back('{id: i, data: 0, cyc: cyc + 1});
      if (rsp_valid) rlog.push_back('{id: int'(rsp_id), data: int'(rsp_data), cyc: cyc});
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(acc_mask & ~hold);
    end
  endtask

  task automatic setreq(int i, int op, int a, int b);
    req_opcode[2*i +: 2] = 2'(op);
    req_a[8*i +: 8] = 8'(a);
    req_b[8*i +: 8] = 8'(b);
    req_valid[i] = 1'b1;
  endtask

  task automatic clear_logs();
    glog.delete();
    rlog.delete();
  endtask

  initial begin
    int e, t_en;
    int exp_d[4] = '{8, 3, 4, 15};
    rst = 1'b1; en = 1'b0; req_valid = '0;
    req_opcode = '0; req_a = '0; req_b = '0;
    tick(3);
    rst = 1'b0;
    tick();
    // single request: 5+3 returns three edges after accept
    setreq(0, 0, 5, 3);
    en = 1'b1;
    tick(8);
    chk("single_grants", glog.size(), 1);
    chk("single_rsps", rlog.size(), 1);
    if (glog.size() > 0 && rlog.size() > 0) begin
      e = glog[0].cyc;
      chk("single_id", rlog[0].id, 0);
      chk("single_data", rlog[0].data, 8);
      chk("single_latency", rlog[0].cyc - e, 3);
      chk("idle_before", int'(idle_h[e-1]), 1);
      chk("idle_fall", int'(idle_h[e]), 0);
      chk("idle_busy", int'(idle_h[e+LAT+1]), 0);
      chk("idle_rise", int'(idle_h[e+LAT+2]), 1);
    end
    // all four from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
    setreq(0, 0, 5, 3); setreq(1, 1, 10, 7); setreq(2, 2, 12, 5); setreq(3, 3, 9, 6);
    tick(10);
    chk("all4_grants", glog.size(), 4);
    chk("all4_rsps", rlog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size() && i < rlog.size(); i++) begin
      chk("all4_grant_id", glog[i].id, i);
      chk("all4_grant_cyc", glog[i].cyc - glog[0].cyc, i);
      chk("all4_rsp_id", rlog[i].id, i);
      chk("all4_rsp_data", rlog[i].data, exp_d[i]);
      chk("all4_rsp_cyc", rlog[i].cyc - rlog[0].cyc, i);
    end
    // fairness between two always-valid requesters
    clear_logs();
    hold = 4'b0101;
    setreq(0, 0, 1, 2); setreq(2, 3, 4, 8);
    tick(8);
    hold = '0;
    req_valid = '0;
    tick(6);
    chk("fair_grants", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) chk("fair_id", glog[i].id, (i % 2) * 2);
    // enable drop with one op in flight
    clear_logs();
    setreq(0, 0, 200, 100);
    tick();
    en = 1'b0;
    setreq(1, 1, 7, 9);
    repeat (5) begin
      tick();
      chk("en_off_ready", int'(req_ready), 0);
    end
    en = 1'b1;
    t_en = cyc;
    tick(6);
    chk("en_grants", glog.size(), 2);
    chk("en_rsps", rlog.size(), 2);
    if (glog.size() == 2 && rlog.size() == 2) begin
      chk("en_regrant_id", glog[1].id, 1);
      chk("en_regrant_cyc", glog[1].cyc, t_en + 1);
      chk("en_inflight_data", rlog[0].data, 44);
      chk("en_inflight_during_off", int'(rlog[0].cyc < t_en), 1);
      chk("en_late_data", rlog[1].data, 254);
    end
    // reset with two ops in flight
    clear_logs();
    setreq(0, 2, 255, 15); setreq(1, 3, 1, 2);
    tick(2);
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick(6);
    chk("rst_flush_rsps", rlog.size(), 0);
    chk("rst_flush_idle", int'(idle), 1);
    setreq(3, 0, 1, 1); setreq(0, 0, 2, 2);
    tick(6);
    chk("rst_grants", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("rst_first_grant", glog[2].id, 0);
      chk("rst_second_grant", glog[3].id, 3);
    end
    chk("rst_new_rsps", rlog.size(), 2);
    // random traffic with occasional enable drops and resets
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom % 80) == 0;
      en = ($urandom % 6) != 0;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && ($urandom % 2))
          setreq(i, int'($urandom % 4), int'($urandom % 256), int'($urandom % 256));
      tick();
    end
    rst = 1'b0;
    en = 1'b1;
    req_valid = '0;
    tick(8);
    chk("final_idle", int'(idle), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
